// File: rtl/cond_pkg.sv
// Shared condition-code encodings and NZCV bit positions for the
// condition-check / write-gating stage.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Bundle between the main control FSM/decoder (master) and the
// condition-check stage (slave).
interface cond_logic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       Branch;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       FpuW;
  logic       Src_64b;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       FpuWrite;
  logic       Write64;
  logic [3:0] Flags;
  logic       CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, Branch, NextPC, RegW, MemW, FpuW, Src_64b,
    input  PCWrite, RegWrite, MemWrite, FpuWrite, Write64, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, Branch, NextPC, RegW, MemW, FpuW, Src_64b,
    output PCWrite, RegWrite, MemWrite, FpuWrite, Write64, Flags, CondEx
  );
endinterface

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit condition field against NZCV.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // NV is deliberately treated as always so it can never suppress a write.
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Holds the architectural NZCV flags and gates the FSM's raw write strobes
// with the condition result registered one cycle earlier.
module cond_logic
  import cond_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);

  logic [3:0] flags_q;
  logic       cond_ex_c;
  logic       cond_ex_d;
  logic [1:0] flag_write;

  cond_check u_cond_check (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex_c)
  );

  assign flag_write = bus.FlagW & {2{cond_ex_c}};

  // N/Z and C/V halves update independently; evaluation always sees pre-update flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= 4'b0000;
      cond_ex_d <= 1'b0;
    end else begin
      if (flag_write[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (flag_write[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
      cond_ex_d <= cond_ex_c;
    end
  end

  assign bus.PCWrite  = ((bus.PCS | bus.Branch) & cond_ex_d) | bus.NextPC;
  assign bus.RegWrite = bus.RegW & cond_ex_d;
  assign bus.MemWrite = bus.MemW & cond_ex_d;
  assign bus.FpuWrite = bus.FpuW & cond_ex_d;
  assign bus.Write64  = bus.Src_64b & bus.RegW & cond_ex_d;
  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex_d;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: reference model plus directed literal checks.
module tb_cond_logic;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  cond_logic_if bus ();

  cond_logic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] m_flags;
  logic       m_condex;

  // Conditions come in complementary pairs; odd codes below 1110 invert the even one.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c >= 4'd14) return 1'b1;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_flags  <= 4'b0000;
      m_condex <= 1'b0;
    end else begin
      m_condex <= model_cond(bus.Cond, m_flags);
      if (model_cond(bus.Cond, m_flags)) begin
        if (bus.FlagW[1]) m_flags[3:2] <= bus.ALUFlags[3:2];
        if (bus.FlagW[0]) m_flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_flags",   32'(bus.Flags),    32'(m_flags));
    checkOutput("model_condex",  32'(bus.CondEx),   32'(m_condex));
    checkOutput("model_pcwrite", 32'(bus.PCWrite),
                32'(((bus.PCS | bus.Branch) & m_condex) | bus.NextPC));
    checkOutput("model_regwrite", 32'(bus.RegWrite), 32'(bus.RegW & m_condex));
    checkOutput("model_memwrite", 32'(bus.MemWrite), 32'(bus.MemW & m_condex));
    checkOutput("model_fpuwrite", 32'(bus.FpuWrite), 32'(bus.FpuW & m_condex));
    checkOutput("model_write64",  32'(bus.Write64),  32'(bus.Src_64b & bus.RegW & m_condex));
  end

  task automatic applyStimulus(input logic [3:0] cond, input logic [1:0] flagw,
                               input logic [3:0] aluflags, input logic [6:0] strobes);
    bus.Cond     = cond;
    bus.FlagW    = flagw;
    bus.ALUFlags = aluflags;
    {bus.PCS, bus.Branch, bus.NextPC, bus.RegW, bus.MemW, bus.FpuW, bus.Src_64b} = strobes;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // strobe order: PCS Branch NextPC RegW MemW FpuW Src_64b
  initial begin
    applyStimulus(4'b1110, 2'b11, 4'b1111, 7'b1111111);
    repeat (3) tick();
    checkOutput("rst_flags",    32'(bus.Flags),    32'h0);
    checkOutput("rst_condex",   32'(bus.CondEx),   32'h0);
    checkOutput("rst_pcwrite",  32'(bus.PCWrite),  32'h1);
    checkOutput("rst_regwrite", 32'(bus.RegWrite), 32'h0);
    checkOutput("rst_memwrite", 32'(bus.MemWrite), 32'h0);
    checkOutput("rst_write64",  32'(bus.Write64),  32'h0);

    reset = 1'b1;
    applyStimulus(4'b1110, 2'b11, 4'b0100, 7'b0000000);
    tick();
    checkOutput("flag_load", 32'(bus.Flags), 32'h4);

    applyStimulus(4'b0000, 2'b00, 4'b0000, 7'b0001000);
    tick();
    checkOutput("eq_condex",   32'(bus.CondEx),   32'h1);
    checkOutput("eq_regwrite", 32'(bus.RegWrite), 32'h1);

    applyStimulus(4'b0001, 2'b11, 4'b1011, 7'b0100100);
    tick();
    checkOutput("ne_condex",   32'(bus.CondEx),   32'h0);
    checkOutput("ne_memwrite", 32'(bus.MemWrite), 32'h0);
    checkOutput("ne_pcwrite",  32'(bus.PCWrite),  32'h0);
    checkOutput("ne_flags",    32'(bus.Flags),    32'h4);

    applyStimulus(4'b1110, 2'b01, 4'b1011, 7'b0000000);
    tick();
    checkOutput("cv_only_flags", 32'(bus.Flags), 32'h7);

    for (int f = 0; f < 16; f++) begin
      applyStimulus(4'b1110, 2'b11, 4'(f), 7'b0001000);
      tick();
      for (int c = 0; c < 16; c++) begin
        applyStimulus(4'(c), 2'b00, 4'hf, 7'b0001000);
        tick();
      end
    end

    // Flags now 1111: pin a few table entries by hand.
    applyStimulus(4'b1100, 2'b00, 4'h0, 7'b0000000);
    tick();
    checkOutput("gt_z_set", 32'(bus.CondEx), 32'h0);
    applyStimulus(4'b1111, 2'b00, 4'h0, 7'b0000000);
    tick();
    checkOutput("nv_always", 32'(bus.CondEx), 32'h1);

    applyStimulus(4'b1110, 2'b11, 4'b0000, 7'b0001011);
    tick();
    applyStimulus(4'b1110, 2'b00, 4'b0000, 7'b0001011);
    tick();
    checkOutput("al_write64",  32'(bus.Write64),  32'h1);
    checkOutput("al_regwrite", 32'(bus.RegWrite), 32'h1);
    checkOutput("al_fpuwrite", 32'(bus.FpuWrite), 32'h1);
    applyStimulus(4'b0000, 2'b00, 4'b0000, 7'b0001011);
    tick();
    checkOutput("eq_write64",  32'(bus.Write64),  32'h0);
    checkOutput("eq_regwrite", 32'(bus.RegWrite), 32'h0);
    checkOutput("eq_fpuwrite", 32'(bus.FpuWrite), 32'h0);

    applyStimulus(4'b1110, 2'b00, 4'b0000, 7'b0001000);
    tick();
    checkOutput("pre_rst_regwrite", 32'(bus.RegWrite), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("async_rst_condex", 32'(bus.CondEx), 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("post_rst_regwrite", 32'(bus.RegWrite), 32'h0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Condition-check and write-gating stage directly downstream of the multicycle main control FSM. It holds the architectural NZCV flags and evaluates each instruction's 4-bit condition field against them. It gates the FSM's raw write strobes (NextPC/Branch, RegW, MemW, FpuW, Src_64b) into the final enables seen by the PC register, register file, data memory and FPU writeback. Flag updates are enabled by the decoder's FlagW.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- Cond  in  4  instruction condition field (Instr[31:28])
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- FlagW  in  2  [1]: update N,Z; [0]: update C,V (from decoder)
- PCS  in  1  decoder: instruction writes R15
- Branch  in  1  FSM: branch state
- NextPC  in  1  FSM: unconditional PC increment (FETCH/DECODE)
- RegW  in  1  FSM raw register write
- MemW  in  1  FSM raw memory write
- FpuW  in  1  FSM raw FPU writeback
- Src_64b  in  1  FSM: 64-bit (two-register) writeback
- PCWrite  out  1  gated PC enable
- RegWrite  out  1  gated register-file write
- MemWrite  out  1  gated memory write
- FpuWrite  out  1  gated FPU writeback
- Write64  out  1  gated 64-bit writeback select
- Flags  out  4  architectural {N,Z,C,V}
- CondEx  out  1  registered condition result (CondExD)

## Operation
- CondExC (combinational): Cond evaluated against the registered Flags. EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; MI 0100 N; PL 0101 ~N; VS 0110 V; VC 0111 ~V; HI 1000 C&~Z; LS 1001 ~C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1; 1111 1 (treated as always).
- FlagWrite[1:0] = FlagW & {2{CondExC}}.
- On a clock edge with FlagWrite[1], capture Flags[3:2] from ALUFlags[3:2].
- On a clock edge with FlagWrite[0], capture Flags[1:0] from ALUFlags[1:0]. The two halves are independent.
- CondExD register loads CondExC every cycle.
- Outputs (combinational from the registers and the FSM strobes):
  - PCWrite = ((PCS|Branch) & CondExD) | NextPC
  - RegWrite = RegW & CondExD
  - MemWrite = MemW & CondExD
  - FpuWrite = FpuW & CondExD
  - Write64 = Src_64b & RegW & CondExD
- Failed condition: no architectural write of any kind; PC advances only via NextPC.

## Timing
- Reset low: Flags=4'b0000 and CondExD=0 immediately, independent of clk. Gated outputs are 0 except PCWrite, which follows NextPC.
- Reset deasserted mid-instruction: state stays cleared. Because CondExD=0, the pending write of the interrupted instruction is suppressed.
- Flag latency: flags written at edge k are visible on Flags and in CondExC from cycle k+1.
- The gating decision uses CondExD, i.e. the condition sampled one cycle earlier (DECODE/EXECUTE). A flag update in EXECUTE therefore cannot cancel the same instruction's writeback.
- Simultaneous FlagWrite and condition evaluation: CondExC always uses pre-update flags.
- Writes are single-cycle strobes; there is no handshake or back-pressure.

## Structure
- Shared package (cond_pkg): 4-bit condition-code constants (COND_EQ … COND_NV), flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- Sub-module cond_check: purely combinational (Cond, Flags) -> CondExC.
- Top cond_logic: flag registers, CondExD flop, gating.

## Test plan
- Reset low with ALUFlags=4'b1111, FlagW=2'b11 and clk running -> Flags stays 4'b0000 and CondEx=0. With NextPC=1, PCWrite=1 and all other enables 0.
- From Flags=0, Cond=1110, FlagW=2'b11, ALUFlags=4'b0100, one edge -> Flags=4'b0100.
  - Next cycle Cond=0000 -> CondEx=1 one edge later.
  - RegW=1 -> RegWrite=1.
- Flags=4'b0100, Cond=0001 (NE), MemW=1, Branch=1, NextPC=0 -> after the edge CondEx=0, MemWrite=0, PCWrite=0, and Flags unchanged even with FlagW=2'b11.
- FlagW=2'b01 with ALUFlags=4'b1011 from Flags=4'b0100 -> Flags=4'b0111 (N,Z preserved).
- Exhaustive sweep of 16 Cond × 16 Flags -> CondEx matches the table above, including 1111 -> 1.
- Cond=1110, RegW=1, Src_64b=1 -> Write64=1 and RegWrite=1.
  - Repeat with Cond=0000 and Z=0 -> both 0.
  - FpuW=1 in the same conditions gates identically.
